pool_out_writer: RTL and testbench

- Downstream consumer of the pool stage's output interface: out_data / out_data_available / done_pool.
- Captures each pooled row into a small FIFO and writes it to the output BRAM port.
- Address generation: base address plus a per-row stride. Byte enables are taken from validity_mask.
- Signals layer completion once pool has reported done and every captured row has been written.

---
 rtl/pool_out_writer.sv | 172 +++++++++++++++++
 tb/tb_pool_out_writer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_out_writer.sv
// Buffers pooled rows in a small FIFO and writes them to BRAM at base + n*stride.
// Define POOL_OUT_WRITER_ROW_COUNT_EN to add the rows_written counter output.

module pool_out_writer_lane #(
  parameter int DWIDTH = 8
) (
  input  logic              en_i,
  input  logic [DWIDTH-1:0] d_i,
  output logic [DWIDTH-1:0] q_o
);
  assign q_o = en_i ? d_i : '0;
endmodule

module pool_out_writer #(
  parameter int DWIDTH      = 8,
  parameter int DESIGN_SIZE = 16,
  parameter int MASK_WIDTH  = 16,
  parameter int AWIDTH      = 10,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [AWIDTH-1:0]             base_addr,
  input  logic [AWIDTH-1:0]             addr_stride,
  input  logic [MASK_WIDTH-1:0]         validity_mask,
  input  logic [DESIGN_SIZE*DWIDTH-1:0] pool_out_data,
  input  logic                          pool_out_data_available,
  input  logic                          pool_done,
  output logic [AWIDTH-1:0]             bram_addr,
  output logic [DESIGN_SIZE*DWIDTH-1:0] bram_wdata,
  output logic [MASK_WIDTH-1:0]         bram_we,
  input  logic                          bram_ready,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow
`ifdef POOL_OUT_WRITER_ROW_COUNT_EN
  ,
  output logic [AWIDTH-1:0]             rows_written
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int RW = DESIGN_SIZE * DWIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e                                state_q;
  logic [FIFO_DEPTH-1:0][RW-1:0]         dmem_q;
  logic [FIFO_DEPTH-1:0][MASK_WIDTH-1:0] mmem_q;
  logic [PW-1:0]                         wr_ptr_q, rd_ptr_q, sel_idx;
  logic [PW:0]                           cnt_q, cnt_d;
  logic                                  out_vld_q, sel_vld;
  logic [AWIDTH-1:0]                     addr_q, stride_q;
  logic [RW-1:0]                         wdata_q;
  logic [MASK_WIDTH-1:0]                 we_q, sel_mask;
  logic [DESIGN_SIZE-1:0][DWIDTH-1:0]    sel_data, wdata_d;
  logic                                  busy_q, done_q, ovf_q;
  logic                                  accept, push_req, full, push, drop;
`ifdef POOL_OUT_WRITER_ROW_COUNT_EN
  logic [AWIDTH-1:0]                     rows_q;
`endif

  // The presented row stays in the FIFO until accepted; on accept the next
  // entry is staged so back-to-back writes sustain one row per cycle.
  always_comb begin
    accept   = out_vld_q & bram_ready;
    push_req = (state_q == S_RUN) & pool_out_data_available;
    full     = (cnt_q == (PW+1)'(FIFO_DEPTH));
    push     = push_req & (~full | accept);
    drop     = push_req & full & ~accept;
    cnt_d    = cnt_q + (PW+1)'(push) - (PW+1)'(accept);
    if (accept) begin
      sel_idx = rd_ptr_q + PW'(1);
      sel_vld = (cnt_q > (PW+1)'(1));
    end else begin
      sel_idx = rd_ptr_q;
      sel_vld = (cnt_q != '0);
    end
    sel_data = dmem_q[sel_idx];
    sel_mask = sel_vld ? mmem_q[sel_idx] : '0;
  end

  for (genvar i = 0; i < DESIGN_SIZE; i++) begin : g_lane
    pool_out_writer_lane #(.DWIDTH(DWIDTH)) u_lane (
      .en_i (sel_mask[i]),
      .d_i  (sel_data[i]),
      .q_o  (wdata_d[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      dmem_q    <= '0;
      mmem_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      out_vld_q <= 1'b0;
      we_q      <= '0;
      wdata_q   <= '0;
      addr_q    <= '0;
      stride_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
`ifdef POOL_OUT_WRITER_ROW_COUNT_EN
      rows_q    <= '0;
`endif
    end else begin
      if (push) begin
        dmem_q[wr_ptr_q] <= pool_out_data;
        mmem_q[wr_ptr_q] <= validity_mask;
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (accept) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        addr_q   <= addr_q + stride_q;
      end
      cnt_q     <= cnt_d;
      out_vld_q <= sel_vld;
      we_q      <= sel_mask;
      wdata_q   <= wdata_d;
      if (drop) ovf_q <= 1'b1;
`ifdef POOL_OUT_WRITER_ROW_COUNT_EN
      if (accept && we_q != '0) rows_q <= rows_q + AWIDTH'(1);
`endif
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          state_q  <= S_RUN;
          busy_q   <= 1'b1;
          addr_q   <= base_addr;
          stride_q <= addr_stride;
          ovf_q    <= 1'b0;
`ifdef POOL_OUT_WRITER_ROW_COUNT_EN
          rows_q   <= '0;
`endif
        end
        S_RUN: if (pool_done) begin
          if (cnt_d != '0) begin
            state_q <= S_DRAIN;
          end else begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DRAIN: if (cnt_d == '0) begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bram_addr  = addr_q;
  assign bram_wdata = wdata_q;
  assign bram_we    = we_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overflow   = ovf_q;
`ifdef POOL_OUT_WRITER_ROW_COUNT_EN
  assign rows_written = rows_q;
`endif

endmodule

// File: tb/tb_pool_out_writer.sv
// Bench for pool_out_writer: table of masked rows plus hand sequences, BRAM writes checked against a scoreboard.
module tb_pool_out_writer;
  localparam int DWIDTH      = 8;
  localparam int DESIGN_SIZE = 16;
  localparam int MASK_WIDTH  = 16;
  localparam int AWIDTH      = 10;
  localparam int FIFO_DEPTH  = 4;
  localparam int RW          = DESIGN_SIZE * DWIDTH;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  start = 1'b0;
  logic [AWIDTH-1:0]     base_addr = '0;
  logic [AWIDTH-1:0]     addr_stride = '0;
  logic [MASK_WIDTH-1:0] validity_mask = '0;
  logic [RW-1:0]         pool_out_data = '0;
  logic                  pool_out_data_available = 1'b0;
  logic                  pool_done = 1'b0;
  logic [AWIDTH-1:0]     bram_addr;
  logic [RW-1:0]         bram_wdata;
  logic [MASK_WIDTH-1:0] bram_we;
  logic                  bram_ready = 1'b1;
  logic                  busy, done, overflow;
`ifdef POOL_OUT_WRITER_ROW_COUNT_EN
  logic [AWIDTH-1:0]     rows_written;
`endif

  always #5 clk = ~clk;

  pool_out_writer #(
    .DWIDTH(DWIDTH), .DESIGN_SIZE(DESIGN_SIZE), .MASK_WIDTH(MASK_WIDTH),
    .AWIDTH(AWIDTH), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .base_addr(base_addr), .addr_stride(addr_stride),
    .validity_mask(validity_mask), .pool_out_data(pool_out_data),
    .pool_out_data_available(pool_out_data_available), .pool_done(pool_done),
    .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_we(bram_we),
    .bram_ready(bram_ready), .busy(busy), .done(done), .overflow(overflow)
`ifdef POOL_OUT_WRITER_ROW_COUNT_EN
    , .rows_written(rows_written)
`endif
  );

  typedef struct {
    logic [AWIDTH-1:0]     addr;
    logic [MASK_WIDTH-1:0] we;
    logic [RW-1:0]         wdata;
  } wr_t;

  typedef struct {
    logic [7:0]            b;
    logic [MASK_WIDTH-1:0] mask;
    logic [RW-1:0]         exp_wdata;
  } vec_t;

  wr_t               sb[$];
  int                checks = 0, errors = 0, cyc = 0;
  int                done_cnt = 0, done_cyc = 0, wr_cnt = 0, first_wr = 0, last_wr = 0;
  logic [AWIDTH-1:0] exp_addr = '0, exp_stride = '0;
  bit                tog = 1'b0;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] mkrow(input logic [7:0] s);
    logic [RW-1:0] r;
    for (int i = 0; i < DESIGN_SIZE; i++) r[i*DWIDTH +: DWIDTH] = s + 8'(i);
    return r;
  endfunction

  function automatic logic [RW-1:0] mask_row(input logic [RW-1:0] d, input logic [MASK_WIDTH-1:0] m);
    logic [RW-1:0] r;
    for (int i = 0; i < DESIGN_SIZE; i++) r[i*DWIDTH +: DWIDTH] = m[i] ? d[i*DWIDTH +: DWIDTH] : 8'h00;
    return r;
  endfunction

  task automatic monitor();
    wr_t e;
    if (reset_n && bram_ready && bram_we != '0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr=0x%0h we=0x%0h", bram_addr, bram_we);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", RW'(bram_addr), RW'(e.addr));
        chk("wr_we", RW'(bram_we), RW'(e.we));
        chk("wr_data", bram_wdata, e.wdata);
        if (wr_cnt == 0) first_wr = cyc;
        last_wr = cyc;
        wr_cnt++;
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    if (tog) bram_ready = ~bram_ready;
  endtask

  task automatic begin_layer(input logic [AWIDTH-1:0] b, input logic [AWIDTH-1:0] s);
    base_addr   = b;
    addr_stride = s;
    start       = 1'b1;
    exp_addr    = b;
    exp_stride  = s;
    wr_cnt      = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic drive_row(input logic [RW-1:0] d, input logic [MASK_WIDTH-1:0] m,
                           input logic [RW-1:0] ew, input bit last, input bit keep);
    wr_t e;
    if (keep) begin
      if (m != '0) begin
        e.addr  = exp_addr;
        e.we    = m;
        e.wdata = ew;
        sb.push_back(e);
      end
      exp_addr = exp_addr + exp_stride;
    end
    pool_out_data           = d;
    validity_mask           = m;
    pool_out_data_available = 1'b1;
    pool_done               = last;
    tick();
    pool_out_data_available = 1'b0;
    pool_done               = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < 60) begin
      tick();
      n++;
    end
    chk(name, RW'(done_cnt - d0), RW'(1));
  endtask

  initial begin
    vec_t vt[6];
    int   d0;
    vt[0] = '{8'hAA, 16'hFFFF, {16{8'hAA}}};
    vt[1] = '{8'hAA, 16'h00FF, 128'h0000000000000000_AAAAAAAAAAAAAAAA};
    vt[2] = '{8'h55, 16'hFF00, 128'h5555555555555555_0000000000000000};
    vt[3] = '{8'h3C, 16'h8001, 128'h3C00000000000000_000000000000003C};
    vt[4] = '{8'hF0, 16'h5555, 128'h00F000F000F000F0_00F000F000F000F0};
    vt[5] = '{8'h01, 16'h0001, 128'h0000000000000000_0000000000000001};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", RW'(bram_addr), '0);
    chk("rst_wdata", bram_wdata, '0);
    chk("rst_we", RW'(bram_we), '0);
    chk("rst_busy", RW'(busy), '0);
    chk("rst_done", RW'(done), '0);
    chk("rst_overflow", RW'(overflow), '0);
    reset_n = 1'b1;
    tick();

    // async reset mid-layer with two rows buffered
    bram_ready = 1'b0;
    begin_layer(10'h050, 10'd1);
    drive_row(mkrow(8'h10), 16'hFFFF, '0, 1'b0, 1'b0);
    drive_row(mkrow(8'h20), 16'hFFFF, '0, 1'b0, 1'b0);
    tick();
    chk("h_we_pending", RW'(bram_we), RW'(16'hFFFF));
    chk("h_addr_pending", RW'(bram_addr), RW'(10'h050));
    chk("h_data_pending", bram_wdata, mkrow(8'h10));
    chk("h_busy", RW'(busy), RW'(1));
    reset_n = 1'b0;
    #1;
    chk("h_rst_addr", RW'(bram_addr), '0);
    chk("h_rst_wdata", bram_wdata, '0);
    chk("h_rst_we", RW'(bram_we), '0);
    chk("h_rst_busy", RW'(busy), '0);
    chk("h_rst_done", RW'(done), '0);
    chk("h_rst_overflow", RW'(overflow), '0);
    tick();
    tick();
    reset_n    = 1'b1;
    bram_ready = 1'b1;
    d0 = done_cnt;
    repeat (5) tick();
    chk("h_no_done", RW'(done_cnt), RW'(d0));

    // four rows back to back, done with the last row
    begin_layer(10'h010, 10'd1);
    for (int v = 1; v <= 4; v++)
      drive_row(mkrow(8'(v * 16)), 16'hFFFF, mkrow(8'(v * 16)), v == 4, 1'b1);
    wait_done("c_done");
    chk("c_writes", RW'(wr_cnt), RW'(4));
    chk("c_consecutive", RW'(last_wr - first_wr), RW'(3));
    chk("c_done_gap", RW'(done_cyc - last_wr), RW'(1));
    chk("c_overflow", RW'(overflow), '0);
    chk("c_busy_after", RW'(busy), '0);

    // table of masked rows
    begin_layer(10'h100, 10'd3);
    for (int i = 0; i < 6; i++)
      drive_row({16{vt[i].b}}, vt[i].mask, vt[i].exp_wdata, i == 5, 1'b1);
    wait_done("b_done");
    chk("b_writes", RW'(wr_cnt), RW'(6));

    // stalled BRAM: rows 5 and 6 dropped
    bram_ready = 1'b0;
    begin_layer(10'h080, 10'd1);
    for (int i = 0; i < 6; i++)
      drive_row(mkrow(8'(8'h40 + i * 16)), 16'hFFFF, mkrow(8'(8'h40 + i * 16)), i == 5, i < 4);
    repeat (4) tick();
    chk("d_overflow", RW'(overflow), RW'(1));
    chk("d_addr_hold", RW'(bram_addr), RW'(10'h080));
    chk("d_we_hold", RW'(bram_we), RW'(16'hFFFF));
    bram_ready = 1'b1;
    wait_done("d_done");
    chk("d_writes", RW'(wr_cnt), RW'(4));
    chk("d_overflow_sticky", RW'(overflow), RW'(1));

    // address wrap
    begin_layer(10'h3FE, 10'd2);
    chk("e_overflow_cleared", RW'(overflow), '0);
    for (int i = 0; i < 3; i++)
      drive_row(mkrow(8'(8'hA0 + i)), 16'hFFFF, mkrow(8'(8'hA0 + i)), i == 2, 1'b1);
    wait_done("e_done");
    chk("e_writes", RW'(wr_cnt), RW'(3));

    // all-zero masks, toggling ready, start ignored while busy
    tog = 1'b1;
    begin_layer(10'h020, 10'd4);
    drive_row(mkrow(8'h30), 16'h0000, '0, 1'b0, 1'b1);
    start = 1'b1;
    base_addr = 10'h200;
    addr_stride = 10'd7;
    drive_row(mkrow(8'h40), 16'hFFFF, mask_row(mkrow(8'h40), 16'hFFFF), 1'b0, 1'b1);
    start = 1'b0;
    drive_row(mkrow(8'h50), 16'h0000, '0, 1'b0, 1'b1);
    drive_row(mkrow(8'h60), 16'h00FF, mask_row(mkrow(8'h60), 16'h00FF), 1'b1, 1'b1);
    wait_done("f_done");
    chk("f_writes", RW'(wr_cnt), RW'(2));

    // five rows with ready toggling, then restart and finish an empty layer
    begin_layer(10'h040, 10'd1);
    for (int i = 0; i < 5; i++)
      drive_row(mkrow(8'(8'hC0 + i)), 16'hFFFF, mkrow(8'(8'hC0 + i)), i == 4, 1'b1);
    wait_done("g_done");
    tog = 1'b0;
    bram_ready = 1'b1;
    chk("g_writes", RW'(wr_cnt), RW'(5));
`ifdef POOL_OUT_WRITER_ROW_COUNT_EN
    tick();
    chk("g_rows_written", RW'(rows_written), RW'(5));
`endif
    begin_layer(10'h000, 10'd1);
`ifdef POOL_OUT_WRITER_ROW_COUNT_EN
    chk("g_rows_cleared", RW'(rows_written), '0);
`endif
    chk("g2_busy", RW'(busy), RW'(1));
    pool_done = 1'b1;
    tick();
    pool_done = 1'b0;
    wait_done("g2_empty_done");

    repeat (3) tick();
    chk("sb_empty", RW'(sb.size()), '0);
    chk("done_total", RW'(done_cnt), RW'(7));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
